// File: rtl/stall_ctrl.sv
// Pipeline stall controller: load-use interlock via an aging load tracker plus a multi-cycle op busy counter.
// Optional stall performance counters are built when STALL_PERF_CNT_EN is defined.
module stall_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned MEM_LAT        = 1,
   parameter int unsigned MD_LAT         = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic                      rs1_rd_en_id,
   input  logic                      rs2_rd_en_id,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_id,
   input  logic                      mem_read_id,
   input  logic                      md_op_id,
   input  logic                      flush_ex,
   output logic [3:0]                stall,
   output logic                      issue,
   output logic [31:0]               load_stall_cnt,
   output logic [31:0]               md_stall_cnt
);

   localparam int unsigned MD_W = $clog2(MD_LAT);

   localparam logic [3:0] STALL_NONE = 4'b0000;
   localparam logic [3:0] STALL_LOAD = 4'b0111;
   localparam logic [3:0] STALL_MD   = 4'b1011;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } ld_stage_t;

   ld_stage_t [MEM_LAT-1:0] trk_q, trk_d;
   logic [MD_W-1:0]         md_cnt_q, md_cnt_d;
   logic                    load_hit;
   logic                    md_busy;

   // Hazard detection, issue decision and stall priority
   always_comb begin
      load_hit = 1'b0;
      for (int i = 0; i < int'(MEM_LAT); i++) begin
         if (trk_q[i].valid && (trk_q[i].rd != '0) &&
             ((rs1_rd_en_id && (rs1_addr_id == trk_q[i].rd)) ||
              (rs2_rd_en_id && (rs2_addr_id == trk_q[i].rd)))) begin
            load_hit = 1'b1;
         end
      end
      load_hit = load_hit & id_valid;
      md_busy  = (md_cnt_q != '0);
      issue    = ~rst & id_valid & ~flush_ex & ~load_hit & ~md_busy;

      stall = STALL_NONE;
      if (rst)           stall = STALL_NONE;
      else if (md_busy)  stall = STALL_MD;
      else if (flush_ex) stall = STALL_NONE;
      else if (load_hit) stall = STALL_LOAD;
   end

   // Tracker shifts every cycle; an md op masks a simultaneous load flag
   always_comb begin
      trk_d          = trk_q;
      trk_d[0].valid = issue & mem_read_id & ~md_op_id & (rd_addr_id != '0);
      trk_d[0].rd    = rd_addr_id;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
         trk_d[i] = trk_q[i-1];
      end

      md_cnt_d = md_cnt_q;
      if (issue && md_op_id) md_cnt_d = MD_W'(MD_LAT - 1);
      else if (md_busy)      md_cnt_d = md_cnt_q - MD_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_q    <= '0;
         md_cnt_q <= '0;
      end else begin
         trk_q    <= trk_d;
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [31:0] ld_cnt_q, ld_cnt_d;
   logic [31:0] mdc_cnt_q, mdc_cnt_d;

   always_comb begin
      ld_cnt_d  = ld_cnt_q;
      mdc_cnt_d = mdc_cnt_q;
      if (stall == STALL_LOAD) ld_cnt_d  = ld_cnt_q + 32'd1;
      if (stall == STALL_MD)   mdc_cnt_d = mdc_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_cnt_q  <= '0;
         mdc_cnt_q <= '0;
      end else begin
         ld_cnt_q  <= ld_cnt_d;
         mdc_cnt_q <= mdc_cnt_d;
      end
   end

   assign load_stall_cnt = ld_cnt_q;
   assign md_stall_cnt   = mdc_cnt_q;
`else
   assign load_stall_cnt = 32'd0;
   assign md_stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: two instances (MEM_LAT=1/MD_LAT=4 and MEM_LAT=3/MD_LAT=6) against a cycle-window model.
module tb_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, rs1_en, rs2_en, mem_read, md_op, flush;
   logic [4:0] rs1_addr, rs2_addr, rd_addr;
   logic [3:0] stall0, stall1;
   logic       issue0, issue1;
   logic [31:0] lcnt0, mcnt0, lcnt1, mcnt1;

   int total = 0;
   int bad   = 0;

   int mem_lat [2] = '{1, 3};
   int md_lat  [2] = '{4, 6};
   int last_ld [2][32];
   int md_end  [2];
   int ld_exp  [2];
   int md_exp  [2];
   int cyc = 0;

   always #5 clk = ~clk;

   stall_ctrl #(.REG_ADDR_WIDTH(5), .MEM_LAT(1), .MD_LAT(4)) u_dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .rs1_rd_en_id(rs1_en), .rs2_rd_en_id(rs2_en),
      .rs1_addr_id(rs1_addr), .rs2_addr_id(rs2_addr), .rd_addr_id(rd_addr),
      .mem_read_id(mem_read), .md_op_id(md_op), .flush_ex(flush),
      .stall(stall0), .issue(issue0),
      .load_stall_cnt(lcnt0), .md_stall_cnt(mcnt0)
   );

   stall_ctrl #(.REG_ADDR_WIDTH(5), .MEM_LAT(3), .MD_LAT(6)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .rs1_rd_en_id(rs1_en), .rs2_rd_en_id(rs2_en),
      .rs1_addr_id(rs1_addr), .rs2_addr_id(rs2_addr), .rd_addr_id(rd_addr),
      .mem_read_id(mem_read), .md_op_id(md_op), .flush_ex(flush),
      .stall(stall1), .issue(issue1),
      .load_stall_cnt(lcnt1), .md_stall_cnt(mcnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void reset_model();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 32; r++) last_ld[d][r] = -1000;
         md_end[d] = -1000;
         ld_exp[d] = 0;
         md_exp[d] = 0;
      end
   endfunction

   // A register loaded at cycle L is unavailable during cycles L+1 .. L+MEM_LAT
   function automatic bit pending(input int d, input logic [4:0] r);
      int age;
      age = cyc - last_ld[d][r];
      return (r != 5'd0) && (age >= 1) && (age <= mem_lat[d]);
   endfunction

   task automatic step(input logic v, input logic e1, input logic e2,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                       input logic mr, input logic md, input logic fl);
      logic [3:0]  exp_stall;
      logic        exp_issue, hit, busy;
      logic [31:0] got_l, got_m;
      @(negedge clk);
      id_valid = v; rs1_en = e1; rs2_en = e2; rs1_addr = a1; rs2_addr = a2;
      rd_addr = rd; mem_read = mr; md_op = md; flush = fl;
      #1;
      for (int d = 0; d < 2; d++) begin
         got_l = (d == 0) ? lcnt0 : lcnt1;
         got_m = (d == 0) ? mcnt0 : mcnt1;
`ifdef STALL_PERF_CNT_EN
         chk($sformatf("ld_cnt%0d", d), got_l, 32'(ld_exp[d]));
         chk($sformatf("md_cnt%0d", d), got_m, 32'(md_exp[d]));
`else
         chk($sformatf("ld_cnt%0d", d), got_l, 32'd0);
         chk($sformatf("md_cnt%0d", d), got_m, 32'd0);
`endif
         busy = (cyc < md_end[d]);
         hit  = v && ((e1 && pending(d, a1)) || (e2 && pending(d, a2)));
         exp_issue = v && !fl && !hit && !busy;
         if (busy)     exp_stall = 4'b1011;
         else if (fl)  exp_stall = 4'b0000;
         else if (hit) exp_stall = 4'b0111;
         else          exp_stall = 4'b0000;
         chk($sformatf("stall%0d", d), 32'((d == 0) ? stall0 : stall1), 32'(exp_stall));
         chk($sformatf("issue%0d", d), 32'((d == 0) ? issue0 : issue1), 32'(exp_issue));
         if (exp_stall == 4'b0111) ld_exp[d]++;
         if (exp_stall == 4'b1011) md_exp[d]++;
         if (exp_issue && md)                        md_end[d] = cyc + md_lat[d];
         else if (exp_issue && mr && rd != 5'd0)     last_ld[d][rd] = cyc;
      end
      cyc++;
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_stall0", 32'(stall0), 32'd0);
      chk("rst_stall1", 32'(stall1), 32'd0);
      chk("rst_issue0", 32'(issue0), 32'd0);
      chk("rst_issue1", 32'(issue1), 32'd0);
      chk("rst_cnt0", lcnt0 | mcnt0, 32'd0);
      chk("rst_cnt1", lcnt1 | mcnt1, 32'd0);
      reset_model();
      @(negedge clk);
      id_valid = 1'b0; mem_read = 1'b0; md_op = 1'b0; flush = 1'b0;
      rs1_en = 1'b0; rs2_en = 1'b0;
      rst = 1'b0;
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 1'b1; rs1_en = 1'b1; rs2_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
      rd_addr = 5'd5; mem_read = 1'b1; md_op = 1'b0; flush = 1'b0;
      reset_model();
      #12;
      chk("por_stall0", 32'(stall0), 32'd0);
      chk("por_issue0", 32'(issue0), 32'd0);
      chk("por_stall1", 32'(stall1), 32'd0);
      chk("por_issue1", 32'(issue1), 32'd0);
      @(negedge clk);
      id_valid = 1'b0; mem_read = 1'b0;
      rst = 1'b0;

      // lw x5 then a dependent user of x5
      step(1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0);
      chk("lw_issue", 32'(issue0), 32'd1);
      step(1, 1, 0, 5'd5, 5'd0, 5'd1, 0, 0, 0);
      chk("use_stall0", 32'(stall0), 32'b0111);
      chk("use_issue0", 32'(issue0), 32'd0);
      step(1, 1, 0, 5'd5, 5'd0, 5'd1, 0, 0, 0);
      chk("use_go0", 32'(issue0), 32'd1);
      chk("use_stall1_c2", 32'(stall1), 32'b0111);
      step(1, 1, 0, 5'd5, 5'd0, 5'd1, 0, 0, 0);
      chk("use_stall1_c3", 32'(stall1), 32'b0111);
      step(1, 1, 0, 5'd5, 5'd0, 5'd1, 0, 0, 0);
      chk("use_go1", 32'(issue1), 32'd1);

      // load to x0 never interlocks
      step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      step(1, 0, 1, 5'd0, 5'd0, 5'd2, 0, 0, 0);
      chk("x0_stall1", 32'(stall1), 32'd0);
      chk("x0_issue1", 32'(issue1), 32'd1);

      // multi-cycle op occupancy
      step(1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 0, 0);
         chk("md_stall0", 32'(stall0), 32'b1011);
      end
      step(1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 0, 0);
      chk("md_done0", 32'(stall0), 32'd0);
`ifdef STALL_PERF_CNT_EN
      chk("md_cnt_abs", mcnt0, 32'd3);
`endif
      step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

      // flush masks a load-use stall; the tracker entry still ages out
      step(1, 0, 0, 5'd0, 5'd0, 5'd6, 1, 0, 0);
      step(1, 1, 0, 5'd6, 5'd0, 5'd1, 0, 0, 1);
      chk("fl_stall0", 32'(stall0), 32'd0);
      chk("fl_issue0", 32'(issue0), 32'd0);
      step(1, 1, 0, 5'd6, 5'd0, 5'd1, 0, 0, 0);
      chk("fl_after0", 32'(issue0), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

      // reset in the middle of an md stall
      step(1, 0, 0, 5'd0, 5'd0, 5'd3, 1, 1, 0);
      step(1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 0, 0);
      step(1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 0, 0);
      chk("pre_rst_stall0", 32'(stall0), 32'b1011);
      mid_reset();
      step(1, 1, 1, 5'd5, 5'd6, 5'd3, 0, 0, 0);
      chk("post_rst_issue0", 32'(issue0), 32'd1);

      // randomized traffic with small register range to provoke hazards
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         if (n % 150 == 149) mid_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter MEM_LAT, default 1, legal range 1..4; cycles after load issue before load data is forwardable.
REQ-003 Parameter MD_LAT, default 4, legal range 2..32; total EX occupancy of a multi-cycle (mul/div) op.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 rs1_rd_en_id / rs2_rd_en_id  in  1 each  source operand is used.
REQ-008 rs1_addr_id / rs2_addr_id  in  REG_ADDR_WIDTH each  source addresses.
REQ-009 rd_addr_id  in  REG_ADDR_WIDTH  destination of the ID instruction.
REQ-010 mem_read_id  in  1  ID instruction is a load.
REQ-011 md_op_id  in  1  ID instruction is a multi-cycle op.
REQ-012 flush_ex  in  1  taken branch/mispredict resolved in EX; ID instruction is discarded.
REQ-013 stall  out  4  [0] hold PC, [1] hold IF/ID, [2] bubble into ID/EX, [3] hold ID/EX and bubble into EX/MEM.
REQ-014 issue  out  1  ID instruction advances to EX this cycle.
REQ-015 load_stall_cnt / md_stall_cnt  out  32 each  stall cycle counters (see Configuration).

Function
REQ-016 Load tracker: MEM_LAT-stage shift register, each stage {valid, rd}; advances every cycle regardless of stall.
REQ-017 issue = id_valid & ~flush_ex & ~load_hit & ~md_busy; a load enters stage 0 only when issue & mem_read_id.
REQ-018 load_hit = id_valid & any valid stage whose rd equals a used source address (rsN_rd_en_id & rsN_addr_id == rd), with rd != 0.
REQ-019 Loads with rd = 0 never cause a stall and are not entered into the tracker.
REQ-020 MD counter: on issue & md_op_id load MD_LAT-1; decrement by 1 each cycle while nonzero; md_busy = (counter != 0).
REQ-021 Priority, combinational, same cycle: md_busy -> stall = 4'b1011; else flush_ex -> stall = 4'b0000; else load_hit -> stall = 4'b0111; else 4'b0000.
REQ-022 With MEM_LAT = 1, a load followed by a dependent instruction yields exactly one stall cycle; with MEM_LAT = N, at most N cycles.
REQ-023 flush_ex does not clear tracker entries or the MD counter (older instructions remain in flight).
REQ-024 A load and an md op are never both in ID; if both flags are set, md_op_id takes effect and mem_read_id is ignored.
REQ-025 Load stall and md stall overlapping: md stall reported; tracker keeps advancing so the load stall may expire while md_busy.

Reset
REQ-026 While rst is high: all tracker valid bits 0, MD counter 0, counters 0; stall = 4'b0000, issue = 0.
REQ-027 Reset asserted mid-stall aborts it immediately (asynchronous); first cycle after release behaves as an empty pipeline.

Configuration
REQ-028 Macro STALL_PERF_CNT_EN: when defined, load_stall_cnt increments each cycle stall == 4'b0111 and md_stall_cnt each cycle stall == 4'b1011, wrapping at 2^32.
REQ-029 Without STALL_PERF_CNT_EN both counter outputs are constant 0 and no counter registers are built; all other behaviour is identical.

Verification
REQ-030 MEM_LAT=1: lw x5 issued, next ID uses rs1=x5 -> stall=4'b0111 for 1 cycle, issue=0, then issue=1.
REQ-031 MEM_LAT=3: lw x7, next ID uses rs2=x7 -> stall=4'b0111 for 3 cycles; same with x0 destination -> no stall.
REQ-032 MD_LAT=4: md op issues -> stall=4'b1011 for 3 cycles, then 4'b0000; md_stall_cnt=3 with STALL_PERF_CNT_EN.
REQ-033 Load-use hazard with flush_ex=1 same cycle -> stall=4'b0000, issue=0; tracker entry still ages out.
REQ-034 rst pulsed mid md stall (counter=2) -> stall=4'b0000 asynchronously, counter and tracker cleared, counters 0.
